// File: rtl/shift_code_pkg.sv
// Shared definitions for the shift-register code counter.
//   mode_e       : MODE_JOHNSON (2*WIDTH states) / MODE_RING (WIDTH states)
//   dir_e        : DIR_FWD (shift toward MSB) / DIR_REV (shift toward LSB)
//   canon_start  : canonical start code for a mode, as an integer value
package shift_code_pkg;

  typedef enum logic {
    MODE_JOHNSON = 1'b0,
    MODE_RING    = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  // Johnson starts at all-zeros, ring starts with only bit 0 set.
  function automatic int unsigned canon_start(input logic mode);
    return (mode == MODE_RING) ? 1 : 0;
  endfunction

endpackage

// File: rtl/shift_code_counter_if.sv
// Control/status bundle of shift_code_counter.
//   master : drives en, mode, dir, load, load_val; observes q, state_idx, tc, illegal
//   slave  : the counter side of the same signals
interface shift_code_counter_if #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDXW  = $clog2(2 * WIDTH)
);
  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [IDXW-1:0]  state_idx;
  logic             tc;
  logic             illegal;

  modport master (
    output en, mode, dir, load, load_val,
    input  q, state_idx, tc, illegal
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output q, state_idx, tc, illegal
  );
endinterface

// File: rtl/shift_code_decode.sv
// Combinational decoder for Johnson/ring codes; reusable by monitors.
//   i_q         : code to decode
//   i_mode      : 0 = Johnson, 1 = ring
//   o_legal     : i_q is a legal code for i_mode
//   o_state_idx : position of i_q in the sequence (0 when illegal)
module shift_code_decode
  import shift_code_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDXW  = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_mode,
  output logic             o_legal,
  output logic [IDXW-1:0]  o_state_idx
);

  always_comb begin
    int unsigned ones;
    int unsigned edges;
    int unsigned pos;
    int unsigned idx;
    ones  = 0;
    edges = 0;
    pos   = 0;
    idx   = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_q[i]) begin
        ones = ones + 1;
        pos  = i;
      end
    end
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      if (i_q[i] != i_q[i+1]) edges = edges + 1;
    end

    if (i_mode == MODE_RING) begin
      o_legal = (ones == 1);
      idx     = pos;
    end else begin
      // Filling phase counts ones; draining phase (MSB set) counts down from 2*WIDTH.
      o_legal = (edges <= 1);
      idx     = i_q[WIDTH-1] ? (2 * WIDTH - ones) : ones;
    end
    if (!o_legal) idx = 0;
    o_state_idx = IDXW'(idx);
  end

endmodule

// File: rtl/shift_code_counter.sv
// Run-time selectable Johnson/ring shift-register code counter with load,
// direction, illegal-state self-correction, decoded index and terminal count.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : slave side of shift_code_counter_if (controls in, q/state_idx/tc/illegal out)
module shift_code_counter
  import shift_code_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDXW  = $clog2(2 * WIDTH)
) (
  input logic                 clk,
  input logic                 reset,
  shift_code_counter_if.slave bus
);

  logic [WIDTH-1:0] r_q;
  logic             r_illegal;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_start;
  logic             w_corr;
  logic             w_legal;
  logic             w_load_legal;
  logic [IDXW-1:0]  w_idx;
  logic [IDXW-1:0]  w_last;

  function automatic logic code_legal(input logic [WIDTH-1:0] v, input logic m);
    int unsigned ones;
    int unsigned edges;
    ones  = 0;
    edges = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) ones = ones + 1;
    end
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      if (v[i] != v[i+1]) edges = edges + 1;
    end
    return (m == MODE_RING) ? (ones == 1) : (edges <= 1);
  endfunction

  shift_code_decode #(.WIDTH(WIDTH)) u_decode (
    .i_q         (r_q),
    .i_mode      (bus.mode),
    .o_legal     (w_legal),
    .o_state_idx (w_idx)
  );

  assign w_start      = WIDTH'(canon_start(bus.mode));
  assign w_load_legal = code_legal(bus.load_val, bus.mode);

  // {mode, dir}: Johnson inverts the bit wrapping around, ring rotates it unchanged.
  always_comb begin
    case ({bus.mode, bus.dir})
      {MODE_JOHNSON, DIR_FWD}: w_shift = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
      {MODE_JOHNSON, DIR_REV}: w_shift = {~r_q[0], r_q[WIDTH-1:1]};
      {MODE_RING,    DIR_FWD}: w_shift = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      default:                 w_shift = {r_q[0], r_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    w_next = r_q;
    w_corr = 1'b0;
    if (bus.load) begin
      if (w_load_legal) begin
        w_next = bus.load_val;
      end else begin
        w_next = w_start;
        w_corr = 1'b1;
      end
    end else if (bus.en) begin
      if (w_legal) begin
        w_next = w_shift;
      end else begin
        w_next = w_start;
        w_corr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q       <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_q       <= w_next;
      r_illegal <= w_corr;
    end
  end

  assign w_last = (bus.mode == MODE_RING) ? IDXW'(WIDTH - 1) : IDXW'(2 * WIDTH - 1);

  assign bus.q         = r_q;
  assign bus.illegal   = r_illegal;
  assign bus.state_idx = w_idx;
  assign bus.tc        = bus.en & ~bus.load & w_legal &
                         ((bus.dir == DIR_FWD) ? (w_idx == w_last) : (w_idx == '0));

endmodule
